// File: rtl/wshb_stream_sink.sv
// -----------------------------------------------------------------------------
// wshb_stream_sink
//
// Terminates the video stream bus coming from hw_support and writes the pixels
// into the SDRAM framebuffer read by the vga controller.
//
// Stream (responder) side: 32-bit pixel writes are acknowledged in the request
// cycle whenever the pixel FIFO has room, and the data is queued.
// SDRAM (initiator) side: a two-state FSM drains the FIFO into consecutive
// word addresses, wrapping after HDISP*VDISP pixels. frame_done pulses for one
// cycle after the SDRAM acknowledges the last pixel of a frame.
//
// Parameters:
//   HDISP       active pixels per line
//   VDISP       active lines per frame
//   FIFO_DEPTH  pixel FIFO depth (power of 2, >= 2)
//
// Ports:
//   sys_clk, sys_rst   system clock, synchronous active-high reset
//   s_cyc_i, s_stb_i, s_we_i, s_dat_i       stream responder inputs
//   s_ack_o, s_err_o, s_rty_o, s_dat_o      stream responder outputs
//   m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o, m_cti_o, m_bte_o
//                                           SDRAM writer outputs
//   m_ack_i                                 SDRAM acknowledge
//   frame_done                              one-cycle end-of-frame pulse
//
// Configuration macro: STREAM_SINK_RDERR_EN
//   defined   : a stream read gets err=1, ack=0
//   undefined : a stream read gets ack=1, dat=0, err=0 (no FIFO effect)
// -----------------------------------------------------------------------------
module wshb_stream_sink #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  // stream responder
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [31:0] s_dat_i,
  output logic        s_ack_o,
  output logic        s_err_o,
  output logic        s_rty_o,
  output logic [31:0] s_dat_o,
  // SDRAM writer
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic [2:0]  m_cti_o,
  output logic [1:0]  m_bte_o,
  input  logic        m_ack_i,
  // status
  output logic        frame_done
);

  localparam int NPIX = HDISP * VDISP;
  localparam int PW   = $clog2(NPIX);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // ---------------------------------------------------------------------------
  // Pixel FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic full, empty;
  logic req_w, req_r;
  logic push, pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Stream responder (combinational)
  // ---------------------------------------------------------------------------
  assign req_w = s_cyc_i & s_stb_i & s_we_i;
  assign req_r = s_cyc_i & s_stb_i & ~s_we_i;

  // Fullness comes from the registered count only, so a pop in the same cycle
  // never opens room for a push; this keeps ack free of the SDRAM ack path.
  assign push = req_w & ~full & ~sys_rst;

`ifdef STREAM_SINK_RDERR_EN
  assign s_ack_o = push;
  assign s_err_o = req_r & ~sys_rst;
`else
  assign s_ack_o = push | (req_r & ~sys_rst);
  assign s_err_o = 1'b0;
`endif

  assign s_rty_o = 1'b0;
  assign s_dat_o = 32'h0;

  // ---------------------------------------------------------------------------
  // SDRAM writer FSM
  // ---------------------------------------------------------------------------
  logic [0:0]    state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [PW-1:0] pix_inc;

  logic          m_cyc_q, m_cyc_d;
  logic          m_stb_q, m_stb_d;
  logic          m_we_q,  m_we_d;
  logic [31:0]   m_adr_q, m_adr_d;
  logic [31:0]   m_dat_q, m_dat_d;
  logic [3:0]    m_sel_q, m_sel_d;
  logic [2:0]    m_cti_q, m_cti_d;
  logic [1:0]    m_bte_q, m_bte_d;
  logic          frame_done_q, frame_done_d;

  logic [CW-1:0] count_after;
  logic [31:0]   head_dat;
  logic [31:0]   next_dat;

  function automatic logic [31:0] pix_to_adr(input logic [PW-1:0] pix);
    return 32'({pix, 2'b00});
  endfunction

  assign pop = (state_q == ST_WRITE) & m_ack_i;

  assign pix_inc = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PW'(1);

  assign count_after = count_q - CW'(pop) + CW'(push);

  assign head_dat = mem[rd_ptr_q];

  // Word following the head after a pop. With only one entry stored, the next
  // word can only be the one being pushed this same cycle.
  assign next_dat = (count_q > CW'(1)) ? mem[rd_ptr_q + AW'(1)] : s_dat_i;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    m_cyc_d   = m_cyc_q;
    m_stb_d   = m_stb_q;
    m_we_d    = m_we_q;
    m_adr_d   = m_adr_q;
    m_dat_d   = m_dat_q;
    m_sel_d   = m_sel_q;
    m_cti_d   = m_cti_q;
    m_bte_d   = m_bte_q;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          m_cyc_d = 1'b1;
          m_stb_d = 1'b1;
          m_we_d  = 1'b1;
          m_sel_d = 4'hF;
          m_cti_d = 3'b000;
          m_bte_d = 2'b00;
          m_adr_d = pix_to_adr(pix_cnt_q);
          m_dat_d = head_dat;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (m_ack_i) begin
          pix_cnt_d = pix_inc;
          if (count_after != '0) begin
            m_adr_d = pix_to_adr(pix_inc);
            m_dat_d = next_dat;
          end else begin
            m_cyc_d = 1'b0;
            m_stb_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        m_cyc_d = 1'b0;
        m_stb_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign frame_done_d = pop & (pix_cnt_q == PIX_LAST);

  // ---------------------------------------------------------------------------
  // FIFO pointer/occupancy next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_after;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_q] <= s_dat_i;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      pix_cnt_q    <= '0;
      m_cyc_q      <= 1'b0;
      m_stb_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_adr_q      <= 32'h0;
      m_dat_q      <= 32'h0;
      m_sel_q      <= 4'h0;
      m_cti_q      <= 3'b000;
      m_bte_q      <= 2'b00;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      m_cyc_q      <= m_cyc_d;
      m_stb_q      <= m_stb_d;
      m_we_q       <= m_we_d;
      m_adr_q      <= m_adr_d;
      m_dat_q      <= m_dat_d;
      m_sel_q      <= m_sel_d;
      m_cti_q      <= m_cti_d;
      m_bte_q      <= m_bte_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign m_cyc_o    = m_cyc_q;
  assign m_stb_o    = m_stb_q;
  assign m_we_o     = m_we_q;
  assign m_adr_o    = m_adr_q;
  assign m_dat_o    = m_dat_q;
  assign m_sel_o    = m_sel_q;
  assign m_cti_o    = m_cti_q;
  assign m_bte_o    = m_bte_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_wshb_stream_sink.sv
// -----------------------------------------------------------------------------
// Bench for wshb_stream_sink with a small frame (4x2 pixels) so the address
// wrap and frame_done are reached quickly. Accepted stream writes push their
// expected SDRAM address/data into a queue; a monitor pops it on every SDRAM
// handshake.
// -----------------------------------------------------------------------------
module tb_wshb_stream_sink;

  localparam int HD   = 4;
  localparam int VD   = 2;
  localparam int FD   = 16;
  localparam int NPIX = HD * VD;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        s_cyc_i, s_stb_i, s_we_i;
  logic [31:0] s_dat_i;
  logic        s_ack_o, s_err_o, s_rty_o;
  logic [31:0] s_dat_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [3:0]  m_sel_o;
  logic [2:0]  m_cti_o;
  logic [1:0]  m_bte_o;
  logic        m_ack_i;
  logic        frame_done;
  logic        sd_ack_en = 1'b0;

  wshb_stream_sink #(.HDISP(HD), .VDISP(VD), .FIFO_DEPTH(FD)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .s_cyc_i    (s_cyc_i),
    .s_stb_i    (s_stb_i),
    .s_we_i     (s_we_i),
    .s_dat_i    (s_dat_i),
    .s_ack_o    (s_ack_o),
    .s_err_o    (s_err_o),
    .s_rty_o    (s_rty_o),
    .s_dat_o    (s_dat_o),
    .m_cyc_o    (m_cyc_o),
    .m_stb_o    (m_stb_o),
    .m_we_o     (m_we_o),
    .m_adr_o    (m_adr_o),
    .m_dat_o    (m_dat_o),
    .m_sel_o    (m_sel_o),
    .m_cti_o    (m_cti_o),
    .m_bte_o    (m_bte_o),
    .m_ack_i    (m_ack_i),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  // zero-wait SDRAM model, enabled per test
  assign m_ack_i = sd_ack_en & m_cyc_o & m_stb_o;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   drv_idx   = 0;
  int   fd_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] d);
    exp_t e;
    e.adr = 32'(drv_idx * 4);
    e.dat = d;
    exp_q.push_back(e);
    drv_idx = (drv_idx + 1) % NPIX;
  endtask

  task automatic bus_idle();
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    s_we_i  = 1'b0;
  endtask

  // Returns just after the edge that accepted the write.
  task automatic push_pix(input logic [31:0] d);
    bit ok;
    ok      = 1'b0;
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_we_i  = 1'b1;
    s_dat_i = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge sys_clk);
      if (s_ack_o === 1'b1) begin
        accept(d);
        ok = 1'b1;
      end
      tick();
    end
    bus_idle();
    chk("push_accepted", {31'b0, ok}, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (m_cyc_o === 1'b0 && exp_q.size() == 0) done = 1'b1;
      else tick();
    end
    chk("drain_done", {31'b0, done}, 32'd1);
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    exp_q.delete();
    drv_idx = 0;
    repeat (n) tick();
    sys_rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: SDRAM-side scoreboard and frame_done model
  // ---------------------------------------------------------------------------
  logic fd_exp  = 1'b0;
  int   mon_idx = 0;

  always @(negedge sys_clk) begin
    exp_t e;
    if (frame_done !== 1'b0 || fd_exp) chk("frame_done", {31'b0, frame_done}, {31'b0, fd_exp});
    if (frame_done === 1'b1) fd_pulses++;
    if (sys_rst) begin
      fd_exp  = 1'b0;
      mon_idx = 0;
    end else if (m_cyc_o && m_stb_o && m_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_write: adr 0x%08h dat 0x%08h with no pending pixel", m_adr_o, m_dat_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_adr", m_adr_o, e.adr);
        chk("sb_dat", m_dat_o, e.dat);
        chk("sb_sel", {28'b0, m_sel_o}, 32'hF);
        chk("sb_we",  {31'b0, m_we_o}, 32'd1);
      end
      fd_exp  = (mon_idx == NPIX - 1);
      mon_idx = (mon_idx + 1) % NPIX;
    end else begin
      fd_exp = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int acks;
    int cnt;
    int fd0;
    bit brk;

    // reset with stream writes requested
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_we_i  = 1'b1;
    s_dat_i = 32'h1234_5678;
    repeat (3) tick();
    chk("rst_m_cyc",  {31'b0, m_cyc_o}, 32'd0);
    chk("rst_m_stb",  {31'b0, m_stb_o}, 32'd0);
    chk("rst_m_we",   {31'b0, m_we_o},  32'd0);
    chk("rst_m_adr",  m_adr_o, 32'd0);
    chk("rst_m_dat",  m_dat_o, 32'd0);
    chk("rst_m_sel",  {28'b0, m_sel_o}, 32'd0);
    chk("rst_m_cti",  {29'b0, m_cti_o}, 32'd0);
    chk("rst_m_bte",  {30'b0, m_bte_o}, 32'd0);
    chk("rst_s_ack",  {31'b0, s_ack_o}, 32'd0);
    chk("rst_s_err",  {31'b0, s_err_o}, 32'd0);
    chk("rst_fdone",  {31'b0, frame_done}, 32'd0);
    bus_idle();
    sys_rst = 1'b0;
    tick();

    // single write, SDRAM acks the first stb cycle
    sd_ack_en = 1'b1;
    push_pix(32'h00FF_00AA);
    chk("single_not_early", {31'b0, m_stb_o}, 32'd0);
    tick();
    chk("single_stb", {31'b0, m_stb_o}, 32'd1);
    chk("single_adr", m_adr_o, 32'd0);
    chk("single_dat", m_dat_o, 32'h00FF_00AA);
    tick();
    chk("single_cyc_drop", {31'b0, m_cyc_o}, 32'd0);
    drain();

    // backpressure: SDRAM stalled, 17 writes offered
    sd_ack_en = 1'b0;
    acks      = 0;
    s_cyc_i   = 1'b1;
    s_stb_i   = 1'b1;
    s_we_i    = 1'b1;
    for (int c = 0; c < 24; c++) begin
      s_dat_i = 32'hB000_0000 + 32'(acks);
      @(negedge sys_clk);
      if (s_ack_o === 1'b1) begin
        accept(s_dat_i);
        acks++;
      end
      tick();
    end
    s_dat_i = 32'hB000_0000 + 32'(acks);
    chk("bp_ack_count", 32'(acks), 32'd16);
    chk("bp_stalled", {31'b0, s_ack_o}, 32'd0);
    sd_ack_en = 1'b1;
    cnt = 0;
    @(negedge sys_clk);
    if (m_cyc_o === 1'b1) cnt++;
    chk("bp_full_during_ack", {31'b0, s_ack_o}, 32'd0);
    tick();
    @(negedge sys_clk);
    if (m_cyc_o === 1'b1) cnt++;
    chk("bp_stall_clear", {31'b0, s_ack_o}, 32'd1);
    if (s_ack_o === 1'b1) accept(s_dat_i);
    tick();
    bus_idle();
    brk = 1'b0;
    for (int i = 0; i < 40 && !brk; i++) begin
      @(negedge sys_clk);
      if (m_cyc_o !== 1'b1) brk = 1'b1;
      else begin
        cnt++;
        tick();
      end
    end
    tick();
    chk("bp_throughput", 32'(cnt), 32'd17);
    drain();

    // wrap: 9 pixels from a fresh frame
    do_reset(2);
    tick();
    fd0 = fd_pulses;
    for (int i = 0; i < 9; i++) push_pix(32'hA500_0000 + 32'(i));
    drain();
    repeat (2) tick();
    chk("wrap_fd_pulses", 32'(fd_pulses - fd0), 32'd1);

    // read request on the stream side
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_we_i  = 1'b0;
    @(negedge sys_clk);
`ifdef STREAM_SINK_RDERR_EN
    chk("rd_err", {31'b0, s_err_o}, 32'd1);
    chk("rd_ack", {31'b0, s_ack_o}, 32'd0);
`else
    chk("rd_ack", {31'b0, s_ack_o}, 32'd1);
    chk("rd_err", {31'b0, s_err_o}, 32'd0);
    chk("rd_dat", s_dat_o, 32'd0);
`endif
    chk("rd_rty", {31'b0, s_rty_o}, 32'd0);
    tick();
    bus_idle();
    tick();
    chk("rd_no_fifo", {31'b0, m_cyc_o}, 32'd0);

    // reset in the middle of a stalled burst
    sd_ack_en = 1'b0;
    for (int i = 0; i < 5; i++) push_pix(32'hC000_0000 + 32'(i));
    tick();
    chk("mb_in_write", {31'b0, m_cyc_o}, 32'd1);
    sys_rst = 1'b1;
    exp_q.delete();
    drv_idx = 0;
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    s_we_i  = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    @(negedge sys_clk);
    chk("mb_rst_noack", {31'b0, s_ack_o}, 32'd0);
    tick();
    chk("mb_cyc_drop", {31'b0, m_cyc_o}, 32'd0);
    chk("mb_stb_drop", {31'b0, m_stb_o}, 32'd0);
    bus_idle();
    sys_rst   = 1'b0;
    sd_ack_en = 1'b1;
    tick();
    push_pix(32'hCAFE_0001);
    tick();
    chk("mb_post_stb", {31'b0, m_stb_o}, 32'd1);
    chk("mb_post_adr", m_adr_o, 32'd0);
    drain();

    repeat (3) tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
